// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Fetch control states.
    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_t;

    // Exception vector geometry; bit index equals the mcause code.
    localparam int unsigned EXC_W                  = 16;
    localparam logic [3:0]  EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS_FAULT = 4'd1;

    // Instruction word substituted when a fetch faults (addi x0,x0,0).
    localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

    // Build a one-hot exception vector from an mcause bit index.
    function automatic logic [EXC_W-1:0] exc_vec(input logic [3:0] idx);
        logic [EXC_W-1:0] v;
        v      = {EXC_W{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_checker.sv
// Protocol checks for the fetch unit; no functional logic.
module instr_fetch_unit_checker
    import fetch_pkg::*;
(
    input logic             clk,
    input logic             rst,
    input fetch_state_t     state,
    input logic             imem_resp_valid,
    input logic [EXC_W-1:0] out_exception
);

    // A response may only arrive while a request is outstanding.
    a_resp_legal: assert property (@(posedge clk) disable iff (!rst)
        imem_resp_valid |-> (state == ST_WAIT || state == ST_DRAIN));

    // At most one exception cause is reported per packet.
    a_exc_onehot: assert property (@(posedge clk) disable iff (!rst)
        $onehot0(out_exception));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding
// requests to instruction memory and hands packets to decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [63:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    input  logic             imem_resp_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [EXC_W-1:0] out_exception
);

    fetch_state_t     state_r, state_s;
    logic [63:0]      pc_r, pc_s;
    logic             out_valid_r, out_valid_s;
    logic [63:0]      out_pc_r, out_pc_s;
    logic [31:0]      out_instr_r, out_instr_s;
    logic [EXC_W-1:0] out_exc_r, out_exc_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             outstanding_s;

    // Request is issued only from REQ with an aligned PC, and never in reset.
    assign req_valid_s    = rst && (state_r == ST_REQ) && (pc_r[1:0] == 2'b00);
    assign req_fire_s     = req_valid_s && imem_req_ready;
    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign out_valid      = out_valid_r;
    assign out_pc         = out_pc_r;
    assign out_instr      = out_instr_r;
    assign out_exception  = out_exc_r;

    // A response is still owed if we are waiting and it is not arriving now,
    // or a request is being accepted this very cycle.
    assign outstanding_s = (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !imem_resp_valid)
                         || ((state_r == ST_REQ) && req_fire_s);

    // Next-state and next-output computation; redirect overrides everything.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        out_valid_s = out_valid_r;
        out_pc_s    = out_pc_r;
        out_instr_s = out_instr_r;
        out_exc_s   = out_exc_r;
        if (redirect_valid) begin
            pc_s        = redirect_pc;
            out_valid_s = 1'b0;
            if (outstanding_s) begin
                state_s = ST_DRAIN;
            end else begin
                state_s = ST_REQ;
            end
        end else begin
            case (state_r)
                ST_REQ: begin
                    if (pc_r[1:0] != 2'b00) begin
                        out_valid_s = 1'b1;
                        out_pc_s    = pc_r;
                        out_instr_s = NOP_INSTR;
                        out_exc_s   = exc_vec(EXC_INSTR_MISALIGNED);
                        state_s     = ST_VALID;
                    end else if (req_fire_s) begin
                        state_s = ST_WAIT;
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        out_valid_s = 1'b1;
                        out_pc_s    = pc_r;
                        state_s     = ST_VALID;
                        if (imem_resp_err) begin
                            out_instr_s = NOP_INSTR;
                            out_exc_s   = exc_vec(EXC_INSTR_ACCESS_FAULT);
                        end else begin
                            out_instr_s = imem_resp_data;
                            out_exc_s   = {EXC_W{1'b0}};
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (imem_resp_valid) begin
                        state_s = ST_REQ;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_VALID: begin
                    if (out_ready) begin
                        out_valid_s = 1'b0;
                        if (out_exc_r == {EXC_W{1'b0}}) begin
                            pc_s    = pc_r + 64'd4;
                            state_s = ST_REQ;
                        end else begin
                            state_s = ST_HALT;
                        end
                    end else begin
                        state_s = ST_VALID;
                    end
                end
                ST_HALT: begin
                    state_s = ST_HALT;
                end
                default: begin
                    out_valid_s = 1'b0;
                    state_s     = ST_REQ;
                end
            endcase
        end
    end

    // State, PC and output packet registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_REQ;
            pc_r        <= RESET_PC;
            out_valid_r <= 1'b0;
            out_pc_r    <= 64'd0;
            out_instr_r <= 32'd0;
            out_exc_r   <= {EXC_W{1'b0}};
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            out_valid_r <= out_valid_s;
            out_pc_r    <= out_pc_s;
            out_instr_r <= out_instr_s;
            out_exc_r   <= out_exc_s;
        end
    end

    instr_fetch_unit_checker u_checker (
        .clk             (clk),
        .rst             (rst),
        .state           (state_r),
        .imem_resp_valid (imem_resp_valid),
        .out_exception   (out_exc_r)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model answers requests,
// monitors compare requests and accepted packets against queued expectations.
module tb_instr_fetch_unit;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [15:0] exc;
    } pkt_t;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] out_exception;

    int n_tests = 0;
    int n_fail  = 0;
    int popped  = 0;
    int req_cnt = 0;
    int mem_lat = 0;
    logic [63:0] err_addr = 64'hFFFF_FFFF_FFFF_FFFF;

    pkt_t        pkt_q[$];
    logic [63:0] req_q[$];

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_exception   (out_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [63:0] pc, input logic [31:0] instr, input logic [15:0] exc);
        pkt_t p;
        p.pc = pc; p.instr = instr; p.exc = exc;
        pkt_q.push_back(p);
    endtask

    task automatic wait_popped(input int n);
        int k = 0;
        while (popped < n && k < 60) begin @(posedge clk); #1; k++; end
        chk("wait_popped", 64'(popped), 64'(n));
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (req_cnt < n && k < 60) begin @(posedge clk); #1; k++; end
        chk("wait_reqs", 64'(req_cnt), 64'(n));
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!out_valid && k < 60) begin @(posedge clk); #1; k++; end
        chk("wait_valid", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic do_redirect(input logic [63:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_out_pc"}, out_pc, 64'd0);
        chk({tag, "_out_instr"}, {32'd0, out_instr}, 64'd0);
        chk({tag, "_out_exc"}, {48'd0, out_exception}, 64'd0);
        chk({tag, "_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 64'h0000_0000_8000_0000);
    endtask

    // Memory model plus request monitor: one response per accepted request,
    // mem_lat extra cycles after the zero-wait slot.
    initial begin
        logic        pend;
        logic [63:0] paddr;
        int          cnt;
        pend = 1'b0; paddr = 64'd0; cnt = 0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'd0; imem_resp_err = 1'b0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            imem_resp_err   = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        imem_resp_valid = 1'b1;
                        imem_resp_data  = 32'h1000_0000 | {20'd0, paddr[11:0]};
                        imem_resp_err   = (paddr == err_addr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    req_cnt++;
                    chk("req_expected", 64'(req_q.size() > 0), 64'd1);
                    if (req_q.size() > 0) chk("req_addr", imem_req_addr, req_q.pop_front());
                    pend  = 1'b1;
                    paddr = imem_req_addr;
                    cnt   = mem_lat;
                end
            end
        end
    end

    // Packet monitor: compare every accepted packet against the scoreboard.
    initial begin
        pkt_t e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready && !redirect_valid) begin
                chk("pkt_expected", 64'(pkt_q.size() > 0), 64'd1);
                if (pkt_q.size() > 0) begin
                    e = pkt_q.pop_front();
                    chk("pkt_pc", out_pc, e.pc);
                    chk("pkt_instr", {32'd0, out_instr}, {32'd0, e.instr});
                    chk("pkt_exc", {48'd0, out_exception}, {48'd0, e.exc});
                end
                popped++;
            end
        end
    end

    // Directed stimulus.
    initial begin
        rst = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
        imem_req_ready = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk_reset_outputs("reset");

        // Sequential fetch from RESET_PC.
        req_q.push_back(64'h8000_0000); req_q.push_back(64'h8000_0004);
        req_q.push_back(64'h8000_0008); req_q.push_back(64'h8000_000C);
        push_pkt(64'h8000_0000, 32'h1000_0000, 16'h0000);
        push_pkt(64'h8000_0004, 32'h1000_0004, 16'h0000);
        push_pkt(64'h8000_0008, 32'h1000_0008, 16'h0000);
        out_ready = 1'b1;
        rst = 1'b1;
        wait_popped(1);

        // Backpressure: packet at 0x8000_0004 must hold for 5 cycles.
        out_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_pc", out_pc, 64'h8000_0004);
            chk("stall_instr", {32'd0, out_instr}, 64'h1000_0004);
            chk("stall_exc", {48'd0, out_exception}, 64'd0);
            chk("stall_no_req", {63'd0, imem_req_valid}, 64'd0);
            @(posedge clk); #1;
        end
        mem_lat = 2;
        out_ready = 1'b1;

        // Redirect while WAIT at 0x8000_000C; its late response is dropped.
        wait_reqs(4);
        chk("popped_before_redirect", 64'(popped), 64'd3);
        out_ready = 1'b0;
        req_q.push_back(64'h8000_0100);
        do_redirect(64'h8000_0100);
        chk("drain_no_req", {63'd0, imem_req_valid}, 64'd0);
        wait_valid();
        chk("redir_pc", out_pc, 64'h8000_0100);
        chk("redir_instr", {32'd0, out_instr}, 64'h1000_0100);
        chk("redir_exc", {48'd0, out_exception}, 64'd0);
        chk("redir_reqs", 64'(req_cnt), 64'd5);

        // Access fault at 0x8000_0010, then HALT.
        mem_lat = 0;
        err_addr = 64'h8000_0010;
        req_q.push_back(64'h8000_0010);
        push_pkt(64'h8000_0010, 32'h0000_0013, 16'h0002);
        out_ready = 1'b1;
        do_redirect(64'h8000_0010);
        wait_popped(4);
        for (int i = 0; i < 5; i++) begin
            chk("halt_no_req", {63'd0, imem_req_valid}, 64'd0);
            chk("halt_no_valid", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
        end
        chk("halt_reqs", 64'(req_cnt), 64'd6);

        // Redirect out of HALT resumes at 0x8000_0200.
        out_ready = 1'b0;
        req_q.push_back(64'h8000_0200);
        do_redirect(64'h8000_0200);
        wait_valid();
        chk("resume_pc", out_pc, 64'h8000_0200);
        chk("resume_instr", {32'd0, out_instr}, 64'h1000_0200);
        chk("resume_exc", {48'd0, out_exception}, 64'd0);

        // Misaligned redirect: no request, misaligned exception, HALT.
        out_ready = 1'b1;
        push_pkt(64'h8000_0302, 32'h0000_0013, 16'h0001);
        do_redirect(64'h8000_0302);
        wait_popped(5);
        for (int i = 0; i < 3; i++) begin
            chk("misal_no_req", {63'd0, imem_req_valid}, 64'd0);
            chk("misal_addr", imem_req_addr, 64'h8000_0302);
            @(posedge clk); #1;
        end
        chk("misal_reqs", 64'(req_cnt), 64'd7);

        // Reset asserted mid-WAIT.
        out_ready = 1'b0;
        mem_lat = 3;
        req_q.push_back(64'h8000_0400);
        do_redirect(64'h8000_0400);
        wait_reqs(8);
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); @(posedge clk); #1;
        mem_lat = 0;
        req_q.push_back(64'h8000_0000);
        push_pkt(64'h8000_0000, 32'h1000_0000, 16'h0000);
        out_ready = 1'b1;
        rst = 1'b1;
        wait_popped(6);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        chk("pkt_q_empty", 64'(pkt_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front of the pipeline. Owns the architectural fetch PC and issues single-outstanding requests to the instruction memory port.
- Packages each returned word with its PC and a 16-bit exception vector, then hands it to the fetch/decode pipeline register through a valid/ready pair.
- On a redirect (branch or trap), discards anything in flight and restarts at the new PC.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word emitted alongside a fetch exception.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- redirect_valid  in  1  load redirect_pc and flush the fetch
- redirect_pc  in  64  new fetch PC
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  64  request address, equal to the current PC
- imem_resp_valid  in  1  response strobe
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  access fault on this response
- out_valid  out  1  fetch packet valid toward the fetch/decode register
- out_ready  in  1  downstream accepts; drives that register's enable
- out_pc  out  64  PC of the packet
- out_instr  out  32  instruction of the packet
- out_exception  out  16  one-hot exception vector; bit index equals mcause code

Behaviour:
- Reset, while rst is low, asynchronous:
  - pc=RESET_PC, state=REQ.
  - out_valid=0, out_pc=0, out_instr=0, out_exception=0.
  - imem_req_valid forced to 0.
- States: REQ, WAIT, DRAIN, VALID, HALT. imem_req_valid=1 only in REQ with pc[1:0]==0. imem_req_addr=pc at all times.
- REQ:
  - If pc[1:0]!=0, no request is issued. Next cycle: out_valid=1, out_pc=pc, out_instr=NOP_INSTR, out_exception=16'h0001 (bit0, misaligned). Go to VALID.
  - Else, on imem_req_valid&&imem_req_ready go to WAIT.
- WAIT: on imem_resp_valid, register the packet and go to VALID:
  - out_pc=pc, out_instr=imem_resp_data, out_exception=16'h0000.
  - If imem_resp_err: out_instr=NOP_INSTR, out_exception=16'h0002 (bit1, access fault).
- VALID: out_valid=1 and all out_* held stable until out_ready. On out_ready:
  - out_exception==0: pc<=pc+4 (wraps mod 2^64), out_valid<=0, go to REQ.
  - Otherwise: out_valid<=0, go to HALT.
- HALT: no requests issued; leaves only on redirect.
- Redirect has priority over every other event in every state:
  - pc<=redirect_pc, out_valid<=0.
  - Go to DRAIN if a request is outstanding: state WAIT without a same-cycle resp, state DRAIN without a same-cycle resp, or a REQ-state handshake in the same cycle.
  - Otherwise go to REQ.
- DRAIN: waits for the outstanding response and discards it (no output), then goes to REQ. A redirect during DRAIN updates pc and stays in DRAIN unless the response arrives that cycle, in which case go to REQ.
- imem_resp_valid in REQ, VALID or HALT is illegal; it is ignored and flagged by an assertion.
- A misaligned redirect_pc is accepted as is; it faults in REQ.
- Latency, zero-wait memory: request cycle t, response t+1, out_valid at t+2. Next request the cycle after out_ready.

Decomposition:
- Package fetch_pkg holds:
  - the state enum fetch_state_t;
  - EXC_INSTR_MISALIGNED=0 and EXC_INSTR_ACCESS_FAULT=1 (bit indices);
  - the exception vector width 16;
  - the NOP constant.
- Single module; no sub-module is natural.

Test Plan:
- Reset then memory returning word = 32'h1000_0000|pc[11:0], out_ready=1 -> packets at pc 0x8000_0000, 0x8000_0004, 0x8000_0008 with matching instr and out_exception=0.
- out_ready=0 for 5 cycles with a packet valid at 0x8000_0004 -> out_* stable, no new imem_req_valid. On release, next request addr 0x8000_0008.
- Redirect to 0x8000_0100 while in WAIT, response 3 cycles later -> that response dropped, next request addr 0x8000_0100, no packet from the old PC.
- imem_resp_err=1 at 0x8000_0010 -> out_instr=0x0000_0013, out_exception=0x0002, no further requests. Redirect to 0x8000_0200 resumes fetching there.
- Redirect to 0x8000_0302 -> no request, out_exception=0x0001, out_pc=0x8000_0302, then HALT.
- Assert rst low mid-WAIT -> all outputs 0 immediately. After release, the first request is at 0x8000_0000.
